// File: rtl/line_clear_engine_pkg.sv
// Shared definitions for the line clear engine: default playfield size,
// scoring constants and the controller state encoding.
package line_clear_engine_pkg;

  localparam int DEF_WIDTH  = 10;
  localparam int DEF_HEIGHT = 20;

  localparam logic [31:0] SCORE_SINGLE = 32'd100;
  localparam logic [31:0] SCORE_DOUBLE = 32'd300;
  localparam logic [31:0] SCORE_TRIPLE = 32'd500;
  localparam logic [31:0] SCORE_TETRIS = 32'd800;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    FILL = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/line_clear_engine_score_lut.sv
// Combinational score lookup: base points for the number of cleared rows,
// scaled by (level + 1).
module lc_score_lut
  import line_clear_engine_pkg::*;
#(
  parameter int L_W     = 5,
  parameter int LEVEL_W = 4
) (
  input  logic [L_W-1:0]     lines,
  input  logic [LEVEL_W-1:0] level,
  output logic [31:0]        score
);

  logic [31:0] base;

  // Four or more rows all earn the tetris bonus.
  always_comb begin
    base = 32'd0;
    case (int'(lines))
      0:       base = 32'd0;
      1:       base = SCORE_SINGLE;
      2:       base = SCORE_DOUBLE;
      3:       base = SCORE_TRIPLE;
      default: base = SCORE_TETRIS;
    endcase
    score = base * (32'(level) + 32'd1);
  end

endmodule

// File: rtl/line_clear_engine.sv
// Row-serial line clear engine: scans the captured field bottom-up, drops full
// rows, compacts the rest downward, zero-fills the top and reports the score.
module line_clear_engine
  import line_clear_engine_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int HEIGHT  = DEF_HEIGHT,
  parameter int LEVEL_W = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [HEIGHT-1:0][WIDTH-1:0]   field_in,
  input  logic [LEVEL_W-1:0]             level,
  output logic                           busy,
  output logic                           done,
  output logic [HEIGHT-1:0][WIDTH-1:0]   field_out,
  output logic [$clog2(HEIGHT+1)-1:0]    lines_cleared,
  output logic [31:0]                    score_delta,
  output logic [15:0]                    total_lines
);

  localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int CW = $clog2(HEIGHT+1);
  localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT-1);
  localparam logic [RW-1:0] ROW_ONE  = RW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  state_t state, next_state;

  logic [HEIGHT-1:0][WIDTH-1:0] field_buf;
  logic [RW-1:0]                rd, wr;
  logic [CW-1:0]                count;
  logic [LEVEL_W-1:0]           level_q;
  logic                         row_full;
  logic [31:0]                  score;
  logic [16:0]                  total_sum;
  logic [15:0]                  total_sat;

  assign row_full  = &field_buf[rd];
  assign total_sum = {1'b0, total_lines} + 17'(count);
  assign total_sat = total_sum[16] ? 16'hFFFF : total_sum[15:0];

  lc_score_lut #(
    .L_W     (CW),
    .LEVEL_W (LEVEL_W)
  ) u_score_lut (
    .lines (count),
    .level (level_q),
    .score (score)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // The scan ends after the row at index 0 has been examined; that row may
  // itself be the first full one, so the FILL decision includes row_full.
  always_comb begin
    next_state = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: if (start) next_state = SCAN;
      SCAN: begin
        busy = 1'b1;
        if (rd == '0) next_state = (count != '0 || row_full) ? FILL : DONE;
      end
      FILL: begin
        busy = 1'b1;
        if (wr == '0) next_state = DONE;
      end
      DONE: begin
        done       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      field_buf     <= '0;
      rd            <= '0;
      wr            <= '0;
      count         <= '0;
      level_q       <= '0;
      field_out     <= '0;
      lines_cleared <= '0;
      score_delta   <= '0;
      total_lines   <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          field_buf <= field_in;
          level_q   <= level;
          rd        <= ROW_LAST;
          wr        <= ROW_LAST;
          count     <= '0;
        end
        SCAN: begin
          rd <= rd - ROW_ONE;
          if (row_full) begin
            count <= count + CNT_ONE;
          end else begin
            field_buf[wr] <= field_buf[rd];
            wr            <= wr - ROW_ONE;
          end
        end
        FILL: begin
          field_buf[wr] <= '0;
          wr            <= wr - ROW_ONE;
        end
        DONE: begin
          field_out     <= field_buf;
          lines_cleared <= count;
          score_delta   <= score;
          total_lines   <= total_sat;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_line_clear_engine.sv
// Self-checking bench for line_clear_engine: directed table, corner-case
// sequences and randomized fields checked against a queue-based model.
module tb_line_clear_engine;

  localparam int W  = 10;
  localparam int H  = 20;
  localparam int LW = 4;
  localparam int CW = $clog2(H+1);

  typedef logic [H-1:0][W-1:0] field_t;

  typedef struct {
    field_t fld;
    int     lvl;
    int     exp_l;
    int     exp_score;
    field_t exp_out;
  } vec_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  field_t          field_in;
  logic [LW-1:0]   level;
  logic            busy;
  logic            done;
  field_t          field_out;
  logic [CW-1:0]   lines_cleared;
  logic [31:0]     score_delta;
  logic [15:0]     total_lines;

  int total = 0;
  int bad   = 0;
  int exp_total = 0;

  vec_t vecs[6];

  line_clear_engine #(
    .WIDTH   (W),
    .HEIGHT  (H),
    .LEVEL_W (LW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .field_in      (field_in),
    .level         (level),
    .busy          (busy),
    .done          (done),
    .field_out     (field_out),
    .lines_cleared (lines_cleared),
    .score_delta   (score_delta),
    .total_lines   (total_lines)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic cmpField(input string name, input field_t act, input field_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: keep non-full rows in top-to-bottom order, stack them at the bottom.
  function automatic void model(input field_t f, input int lvl,
                                output field_t o, output int l, output int score);
    logic [W-1:0] kept[$];
    int pts[5] = '{0, 100, 300, 500, 800};
    logic [W-1:0] full_row;
    full_row = '1;
    kept.delete();
    for (int r = 0; r < H; r++)
      if (f[r] !== full_row) kept.push_back(f[r]);
    l = H - kept.size();
    o = '0;
    for (int i = 0; i < kept.size(); i++) o[l + i] = kept[i];
    score = pts[(l > 4) ? 4 : l] * (lvl + 1);
  endfunction

  // Runs one operation; optional start poke mid-op, reset mid-op, or start during DONE.
  task automatic applyStimulus(input field_t f, input int lvl, input int poke_cyc,
                               input int rst_cyc, input bit poke_done,
                               output int cyc, output bit got);
    @(negedge clk);
    field_in = f;
    level    = LW'(lvl);
    start    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    field_in = ~f;
    level    = LW'(~lvl);
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 60) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      rst   = 1'b0;
      if (cyc == 1 && rst_cyc == 0) cmp("busy_in_scan", busy, 1);
      if (rst_cyc > 0 && cyc == rst_cyc + 1) begin
        cmp("rst_busy", busy, 0);
        cmp("rst_lines", lines_cleared, 0);
        cmp("rst_score", score_delta, 0);
        cmp("rst_total", total_lines, 0);
        cmpField("rst_field", field_out, '0);
      end
      if (done) begin
        got = 1'b1;
        if (poke_done) start = 1'b1;
      end else begin
        if (cyc == poke_cyc) start = 1'b1;
        if (cyc == rst_cyc) rst = 1'b1;
      end
    end
    @(negedge clk);
    start = 1'b0;
    rst   = 1'b0;
  endtask

  // Called in the IDLE cycle right after done.
  task automatic checkOutput(input string tag, input int cyc, input bit got,
                             input int exp_l, input int exp_score, input field_t exp_out);
    cmp({tag, "_done_seen"}, got, 1);
    if (got) cmp({tag, "_done_cycle"}, cyc, H + exp_l + 1);
    cmp({tag, "_done_pulse"}, done, 0);
    cmp({tag, "_busy_idle"}, busy, 0);
    cmp({tag, "_lines"}, lines_cleared, exp_l);
    cmp({tag, "_score"}, score_delta, exp_score);
    cmpField({tag, "_field"}, field_out, exp_out);
    cmp({tag, "_total"}, total_lines, exp_total);
  endtask

  initial begin
    int cyc;
    bit got;
    field_t f, mo;
    int ml, ms, lvl;
    logic [W-1:0] row;

    rst = 1'b1;
    start = 1'b0;
    field_in = '0;
    level = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    cmp("reset_busy", busy, 0);
    cmp("reset_done", done, 0);
    cmp("reset_lines", lines_cleared, 0);
    cmp("reset_score", score_delta, 0);
    cmp("reset_total", total_lines, 0);
    cmpField("reset_field", field_out, '0);
    rst = 1'b0;

    vecs[0].fld = '0; vecs[0].fld[19] = 10'h1FF; vecs[0].lvl = 0;
    vecs[0].exp_l = 0; vecs[0].exp_score = 0; vecs[0].exp_out = vecs[0].fld;

    vecs[1].fld = '0; vecs[1].fld[19] = 10'h3FF; vecs[1].fld[18] = 10'h001; vecs[1].lvl = 0;
    vecs[1].exp_l = 1; vecs[1].exp_score = 100;
    vecs[1].exp_out = '0; vecs[1].exp_out[19] = 10'h001;

    vecs[2].fld = '0; for (int r = 16; r < 20; r++) vecs[2].fld[r] = 10'h3FF;
    vecs[2].fld[15] = 10'h2AA; vecs[2].lvl = 2;
    vecs[2].exp_l = 4; vecs[2].exp_score = 2400;
    vecs[2].exp_out = '0; vecs[2].exp_out[19] = 10'h2AA;

    vecs[3].fld = '0; vecs[3].fld[19] = 10'h3FF; vecs[3].fld[17] = 10'h3FF;
    vecs[3].fld[18] = 10'h0F0; vecs[3].fld[16] = 10'h00F; vecs[3].lvl = 0;
    vecs[3].exp_l = 2; vecs[3].exp_score = 300;
    vecs[3].exp_out = '0; vecs[3].exp_out[19] = 10'h0F0; vecs[3].exp_out[18] = 10'h00F;

    vecs[4].fld = '1; vecs[4].lvl = 3;
    vecs[4].exp_l = 20; vecs[4].exp_score = 3200; vecs[4].exp_out = '0;

    vecs[5].fld = '0; vecs[5].lvl = 5;
    vecs[5].exp_l = 0; vecs[5].exp_score = 0; vecs[5].exp_out = '0;

    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].fld, vecs[i].lvl, 0, 0, 1'b0, cyc, got);
      exp_total += vecs[i].exp_l;
      checkOutput($sformatf("vec%0d", i), cyc, got, vecs[i].exp_l, vecs[i].exp_score, vecs[i].exp_out);
    end

    applyStimulus(vecs[1].fld, 0, 5, 0, 1'b0, cyc, got);
    exp_total += 1;
    checkOutput("restart_ignored", cyc, got, 1, 100, vecs[1].exp_out);

    applyStimulus(vecs[3].fld, 0, 0, 0, 1'b1, cyc, got);
    exp_total += 2;
    checkOutput("start_at_done", cyc, got, 2, 300, vecs[3].exp_out);
    @(negedge clk);
    cmp("start_at_done_still_idle", busy, 0);

    applyStimulus(vecs[4].fld, 1, 0, 8, 1'b0, cyc, got);
    exp_total = 0;
    cmp("rst_no_done", got, 0);
    cmp("rst_done_low", done, 0);

    for (int n = 0; n < 30; n++) begin
      f = '0;
      for (int r = 0; r < H; r++) begin
        row = W'($urandom);
        f[r] = ($urandom_range(0, 2) == 0) ? '1 : row;
      end
      lvl = $urandom_range(0, 15);
      model(f, lvl, mo, ml, ms);
      applyStimulus(f, lvl, 0, 0, 1'b0, cyc, got);
      exp_total = (exp_total + ml > 65535) ? 65535 : exp_total + ml;
      checkOutput($sformatf("rand%0d", n), cyc, got, ml, ms, mo);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/line_clear_engine.md
LINE_CLEAR_ENGINE -- requirements
Module: line_clear_engine

Interface
REQ-001 SHALL have parameter WIDTH, default 10, meaning playfield columns.
REQ-002 SHALL have parameter HEIGHT, default 20, meaning playfield rows; row 0 is the top row, row HEIGHT-1 the bottom row.
REQ-003 SHALL have parameter LEVEL_W, default 4, meaning level input width.
REQ-004 clk  input  1  single clock; all logic on posedge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 start  input  1  one-cycle request to process field_in.
REQ-007 field_in  input  HEIGHT x WIDTH packed  cell occupancy after piece lock; 1 means filled.
REQ-008 level  input  LEVEL_W  current level, sampled with start.
REQ-009 busy  output  1  high from the cycle after start acceptance until done.
REQ-010 done  output  1  one-cycle pulse; results valid.
REQ-011 field_out  output  HEIGHT x WIDTH packed  compacted field, held until the next done.
REQ-012 lines_cleared  output  clog2(HEIGHT+1)  full rows removed in the last operation.
REQ-013 score_delta  output  32  points for the last operation.
REQ-014 total_lines  output  16  saturating running total of cleared rows.

Function
REQ-015 SHALL accept start only in IDLE; start in any other state SHALL be ignored with no side effects.
REQ-016 On acceptance (cycle 0), SHALL capture field_in into an internal buffer and level into a register, set rd=wr=HEIGHT-1 and count=0, and enter SCAN.
REQ-017 SCAN SHALL process one row per cycle, bottom-up: if buf[rd] is all ones, rd--, count++; otherwise buf[wr]<=buf[rd], rd--, wr--.
REQ-018 SCAN SHALL last exactly HEIGHT cycles, then go to FILL if count>0, else to DONE.
REQ-019 FILL SHALL zero buf[wr] and decrement wr once per cycle for exactly count cycles, then go to DONE.
REQ-020 DONE SHALL last one cycle: done=1, field_out<=buf, lines_cleared<=count, score_delta and total_lines updated, then return to IDLE.
REQ-021 done SHALL be high in cycle HEIGHT+L+1 relative to acceptance, where L is the number of full rows.
REQ-022 score_delta SHALL equal base(L)*(level+1), with base(0)=0, base(1)=100, base(2)=300, base(3)=500, and base(L>=4)=800.
REQ-023 total_lines SHALL add L at DONE and saturate at 16'hFFFF.
REQ-024 Rows that are not full SHALL keep their relative order; cells SHALL never be altered within a row.
REQ-025 An all-zero field SHALL produce L=0, score 0, and field_out=0.
REQ-026 An all-full field SHALL produce L=HEIGHT, and field_out SHALL be all zeros after HEIGHT FILL cycles.
REQ-027 start in the same cycle as DONE SHALL be ignored; start is next accepted in the IDLE cycle after done.

Reset
REQ-028 On rst, state SHALL go to IDLE, and busy, done, field_out, lines_cleared, score_delta, total_lines, and the internal buffer SHALL all go to 0.
REQ-029 rst mid-operation SHALL abort the operation: no done pulse, and outputs SHALL be zero the following cycle.
REQ-030 rst SHALL take priority over start.

Structure
REQ-031 The shared package (GLOBAL.sv) SHALL hold the default WIDTH and HEIGHT, the score base constants 100/300/500/800, and the state enum {IDLE, SCAN, FILL, DONE}.
REQ-032 One combinational sub-module, lc_score_lut (inputs L and level; output 32-bit score), SHALL implement REQ-022.
REQ-033 Row-full detection SHALL be a WIDTH-bit AND-reduce on buf[rd] only; there SHALL be no HEIGHT-wide parallel full detection.

Verification (WIDTH=10, HEIGHT=20)
REQ-034 Row 19=0x1FF, all else 0, level 0 -> done at cycle 21, L=0, score 0, field_out==field_in.
REQ-035 Row 19=0x3FF, row 18=0x001, level 0 -> done at cycle 22, L=1, score 100, out row19=0x001, other rows 0.
REQ-036 Rows 16..19=0x3FF, row 15=0x2AA, level 2 -> done at cycle 25, L=4, score 2400, out row19=0x2AA, rows 0..18 = 0.
REQ-037 Rows 19 and 17=0x3FF, row 18=0x0F0, row 16=0x00F -> L=2, score 300, out row19=0x0F0, row18=0x00F, total_lines +2.
REQ-038 start pulsed again in cycle 5 -> ignored and results unchanged; separately, rst in cycle 8 of SCAN -> busy=0 next cycle, no done, all outputs 0.
REQ-039 All-full field -> done at cycle 41, L=20, field_out all 0, score 800*(level+1).
